// File: rtl/pe_dot_accumulator_if.sv
// rtl/pe_dot_accumulator_if.sv - product/result handshake bundle for the PE dot-product accumulator
interface pe_dot_accumulator_if #(
    parameter int WXYZ_BITS = 32
);
    logic                 in_valid;
    logic                 flush;
    logic [WXYZ_BITS-1:0] mul_ae;
    logic [WXYZ_BITS-1:0] mul_be;
    logic [WXYZ_BITS-1:0] mul_ce;
    logic [WXYZ_BITS-1:0] mul_de;
    logic                 out_valid;
    logic                 out_ready;
    logic [WXYZ_BITS-1:0] acc_ae;
    logic [WXYZ_BITS-1:0] acc_be;
    logic [WXYZ_BITS-1:0] acc_ce;
    logic [WXYZ_BITS-1:0] acc_de;
    logic                 overflow;
    logic                 busy;

    modport master (
        output in_valid, flush, mul_ae, mul_be, mul_ce, mul_de, out_ready,
        input  out_valid, acc_ae, acc_be, acc_ce, acc_de, overflow, busy
    );

    modport slave (
        input  in_valid, flush, mul_ae, mul_be, mul_ce, mul_de, out_ready,
        output out_valid, acc_ae, acc_be, acc_ce, acc_de, overflow, busy
    );
endinterface

// File: rtl/pe_dot_accumulator.sv
// rtl/pe_dot_accumulator.sv - four-lane K-beat dot-product accumulator behind the PE multiplier
module pe_dot_accumulator #(
    parameter int WXYZ_BITS   = 32,
    parameter int K_DEPTH     = 4,
    parameter int MUL_LATENCY = 3,
    parameter int SATURATE    = 1
) (
    input logic                clk,
    input logic                rst,
    pe_dot_accumulator_if.slave bus
);
    localparam int W  = WXYZ_BITS;
    localparam int CW = $clog2(K_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(K_DEPTH - 1);

    logic [MUL_LATENCY-1:0] vdly;
    logic [MUL_LATENCY:0]   vnext;
    logic                   beat_v;
    logic [CW-1:0]          cnt;
    logic [3:0][W-1:0]      mul;
    logic [3:0][W-1:0]      acc;
    logic [3:0][W-1:0]      sum;
    logic [3:0][W-1:0]      res;
    logic                   out_valid_r;
    logic                   overflow_r;
    logic                   complete;

    function automatic logic [W-1:0] add_lane(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        if (SATURATE != 0 && (s[W] != s[W-1]))
            add_lane = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            add_lane = s[W-1:0];
    endfunction

    // The multiplier has no valid of its own, so in_valid rides a matching delay line.
    assign vnext  = {vdly, bus.in_valid};
    assign beat_v = vnext[MUL_LATENCY];

    assign mul = {bus.mul_de, bus.mul_ce, bus.mul_be, bus.mul_ae};

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign sum[i] = add_lane(acc[i], mul[i]);
    end

    assign complete = beat_v && (cnt == LAST) && !bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            vdly        <= '0;
            cnt         <= '0;
            acc         <= '0;
            res         <= '0;
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (bus.flush) begin
                vdly <= '0;
                cnt  <= '0;
                acc  <= '0;
            end else begin
                vdly <= vnext[MUL_LATENCY-1:0];
                if (beat_v) begin
                    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                    acc <= (cnt == '0) ? mul : sum;
                end
            end

            // A completion that cannot be stored is dropped and flagged; the held result stays.
            if (complete) begin
                if (!out_valid_r || bus.out_ready) begin
                    res         <= sum;
                    out_valid_r <= 1'b1;
                end else begin
                    overflow_r <= 1'b1;
                end
            end else if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.overflow  = overflow_r;
    assign bus.acc_ae    = res[0];
    assign bus.acc_be    = res[1];
    assign bus.acc_ce    = res[2];
    assign bus.acc_de    = res[3];
    assign bus.busy      = (cnt != '0) | (|vdly);
endmodule

// File: tb/tb_pe_dot_accumulator.sv
// tb/tb_pe_dot_accumulator.sv - directed self-checking bench for pe_dot_accumulator
module tb_pe_dot_accumulator;
    logic clk = 1'b0;
    logic rst;
    int   n_run  = 0;
    int   n_fail = 0;

    pe_dot_accumulator_if #(.WXYZ_BITS(32)) bus_s ();
    pe_dot_accumulator_if #(.WXYZ_BITS(32)) bus_w ();

    pe_dot_accumulator #(.WXYZ_BITS(32), .K_DEPTH(4), .MUL_LATENCY(3), .SATURATE(1)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    pe_dot_accumulator #(.WXYZ_BITS(32), .K_DEPTH(4), .MUL_LATENCY(3), .SATURATE(0)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    always #5 clk = ~clk;

    // Three-stage multiplier stand-in: operands in, products out 3 cycles later, 999 when idle.
    logic [31:0] op_ae, op_be, op_ce, op_de;
    logic [2:0]             pv = '0;
    logic [2:0][3:0][31:0]  pd = '0;

    always @(posedge clk) begin
        pv <= {pv[1:0], bus_s.in_valid};
        pd <= {pd[1:0], {op_de, op_ce, op_be, op_ae}};
    end

    assign bus_s.mul_ae = pv[2] ? pd[2][0] : 32'd999;
    assign bus_s.mul_be = pv[2] ? pd[2][1] : 32'd999;
    assign bus_s.mul_ce = pv[2] ? pd[2][2] : 32'd999;
    assign bus_s.mul_de = pv[2] ? pd[2][3] : 32'd999;

    assign bus_w.in_valid  = bus_s.in_valid;
    assign bus_w.flush     = bus_s.flush;
    assign bus_w.out_ready = bus_s.out_ready;
    assign bus_w.mul_ae    = bus_s.mul_ae;
    assign bus_w.mul_be    = bus_s.mul_be;
    assign bus_w.mul_ce    = bus_s.mul_ce;
    assign bus_w.mul_de    = bus_s.mul_de;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        bus_s.in_valid = iv;
        op_ae = a;
        op_be = b;
        op_ce = c;
        op_de = d;
    endtask

    task automatic idle();
        drive(1'b0, 32'd999, 32'd999, 32'd999, 32'd999);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [31:0] exp);
        check({tag, "_ae"}, bus_s.acc_ae, exp);
        check({tag, "_be"}, bus_s.acc_be, exp);
        check({tag, "_ce"}, bus_s.acc_ce, exp);
        check({tag, "_de"}, bus_s.acc_de, exp);
    endtask

    initial begin
        int ov_cnt;
        bus_s.flush     = 1'b0;
        bus_s.out_ready = 1'b1;
        do_reset();

        check("rst_out_valid", {31'd0, bus_s.out_valid}, 32'd0);
        check_all("rst_acc", 32'd0);
        check("rst_overflow", {31'd0, bus_s.overflow}, 32'd0);
        check("rst_busy", {31'd0, bus_s.busy}, 32'd0);

        // basic dot product
        for (int c = 0; c < 10; c++) begin
            if (c < 4) drive(1'b1, 32'd3, -32'sd2, 32'd100, -32'sd128);
            else idle();
            if (c == 1) check("t1_busy_mid", {31'd0, bus_s.busy}, 32'd1);
            if (c == 6) check("t1_ov_early", {31'd0, bus_s.out_valid}, 32'd0);
            if (c == 7) begin
                check("t1_ov", {31'd0, bus_s.out_valid}, 32'd1);
                check("t1_ae", bus_s.acc_ae, 32'd12);
                check("t1_be", bus_s.acc_be, -32'sd8);
                check("t1_ce", bus_s.acc_ce, 32'd400);
                check("t1_de", bus_s.acc_de, -32'sd512);
                check("t1_busy", {31'd0, bus_s.busy}, 32'd0);
            end
            if (c == 8) begin
                check("t1_ov_consumed", {31'd0, bus_s.out_valid}, 32'd0);
                check("t1_hold_ae", bus_s.acc_ae, 32'd12);
            end
            tick();
        end

        // gapped valid, last in_valid at cycle 5
        for (int c = 0; c < 11; c++) begin
            case (c)
                0: drive(1'b1, 1, 1, 1, 1);
                2: drive(1'b1, 2, 2, 2, 2);
                3: drive(1'b1, 3, 3, 3, 3);
                5: drive(1'b1, 4, 4, 4, 4);
                default: idle();
            endcase
            if (c == 8) check("t2_ov_early", {31'd0, bus_s.out_valid}, 32'd0);
            if (c == 9) begin
                check("t2_ov", {31'd0, bus_s.out_valid}, 32'd1);
                check("t2_ae", bus_s.acc_ae, 32'd10);
                check("t2_de", bus_s.acc_de, 32'd10);
            end
            tick();
        end

        // saturation versus wrap
        for (int c = 0; c < 9; c++) begin
            if (c < 4) drive(1'b1, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000);
            else idle();
            if (c == 7) begin
                check("t3_sat_pos", bus_s.acc_ae, 32'h7FFFFFFF);
                check("t3_wrap_pos", bus_w.acc_ae, 32'hFFFC0000);
            end
            tick();
        end
        for (int c = 0; c < 9; c++) begin
            if (c < 4) drive(1'b1, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
            else idle();
            if (c == 7) begin
                check("t3_sat_neg", bus_s.acc_ae, 32'h80000000);
                check("t3_wrap_neg", bus_w.acc_ae, 32'h00000000);
            end
            tick();
        end

        // backpressure: second result dropped
        bus_s.out_ready = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (c < 4) drive(1'b1, 1, 1, 1, 1);
            else if (c < 8) drive(1'b1, 2, 2, 2, 2);
            else idle();
            if (c == 10) check("t4_no_ovf_yet", {31'd0, bus_s.overflow}, 32'd0);
            if (c == 11) begin
                check("t4_ov_held", {31'd0, bus_s.out_valid}, 32'd1);
                check_all("t4_held", 32'd4);
                check("t4_overflow", {31'd0, bus_s.overflow}, 32'd1);
            end
            if (c == 12) bus_s.out_ready = 1'b1;
            if (c == 13) begin
                check("t4_ov_cleared", {31'd0, bus_s.out_valid}, 32'd0);
                check("t4_ovf_sticky", {31'd0, bus_s.overflow}, 32'd1);
                check("t4_hold_ae", bus_s.acc_ae, 32'd4);
            end
            tick();
        end

        do_reset();
        check("t4_ovf_rst", {31'd0, bus_s.overflow}, 32'd0);

        // flush mid-operation, with a discarded in_valid in the flush cycle
        ov_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            bus_s.flush = (c == 5);
            if (c < 2) drive(1'b1, 5, 5, 5, 5);
            else if (c == 5) drive(1'b1, 100, 100, 100, 100);
            else if (c >= 6 && c < 10) drive(1'b1, 1, 1, 1, 1);
            else idle();
            if (bus_s.out_valid) ov_cnt++;
            if (c == 13) begin
                check("t5_ov", {31'd0, bus_s.out_valid}, 32'd1);
                check_all("t5_acc", 32'd4);
            end
            tick();
        end
        bus_s.flush = 1'b0;
        check("t5_one_result", ov_cnt, 32'd1);
        check("t5_overflow", {31'd0, bus_s.overflow}, 32'd0);

        // reset mid-operation
        bus_s.out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c < 6) drive(1'b1, 1, 1, 1, 1);
            else idle();
            if (c == 9) begin
                check("t6_pre_ov", {31'd0, bus_s.out_valid}, 32'd1);
                check("t6_pre_busy", {31'd0, bus_s.busy}, 32'd1);
                rst = 1'b1;
            end
            tick();
        end
        rst = 1'b0;
        check("t6_ov", {31'd0, bus_s.out_valid}, 32'd0);
        check_all("t6_acc", 32'd0);
        check("t6_busy", {31'd0, bus_s.busy}, 32'd0);
        bus_s.out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c < 4) drive(1'b1, 7, 7, 7, 7);
            else idle();
            if (c == 7) begin
                check("t6_run_ov", {31'd0, bus_s.out_valid}, 32'd1);
                check_all("t6_run", 32'd28);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
